// File: rtl/thread_scheduler_if.sv
// Thread-scheduler bundle: stall/done/exception/config inputs
// and the registered grant outputs toward the IF stage.
interface thread_scheduler_if #(
    parameter int N_THREADS = 8,
    parameter int TID_W     = 3
);
    logic [N_THREADS-1:0] stalled;
    logic [N_THREADS-1:0] done;
    logic                 exc_en;
    logic [TID_W-1:0]     exc_thread;
    logic                 cfg_wen;
    logic [N_THREADS-1:0] cfg_mask;
    logic [TID_W-1:0]     scheduler_thread;
    logic                 issue_valid;
    logic                 all_done;
    logic [31:0]          issue_cnt;

    modport master (
        input  stalled,
        input  done,
        input  exc_en,
        input  exc_thread,
        input  cfg_wen,
        input  cfg_mask,
        output scheduler_thread,
        output issue_valid,
        output all_done,
        output issue_cnt
    );

    modport slave (
        output stalled,
        output done,
        output exc_en,
        output exc_thread,
        output cfg_wen,
        output cfg_mask,
        input  scheduler_thread,
        input  issue_valid,
        input  all_done,
        input  issue_cnt
    );
endinterface

// File: rtl/thread_scheduler.sv
// Barrel round-robin thread selector feeding IF, with an
// exclusive mode that restricts issue to the exception master.
module thread_scheduler #(
    parameter int                   N_THREADS = 8,
    parameter int                   TID_W     = 3,
    parameter int                   QUANTUM   = 1,
    parameter logic [N_THREADS-1:0] RESET_EN  = {N_THREADS{1'b1}}
) (
    input logic                clk,
    input logic                rst,
    thread_scheduler_if.master bus
);
    typedef enum logic {RUN, EXCL} state_e;

    state_e               state_q, state_d;
    logic [TID_W-1:0]     exc_tid_q, exc_tid_d;
    logic [TID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [TID_W-1:0]     thr_q, thr_d;
    logic [3:0]           qcnt_q, qcnt_d;
    logic                 valid_q, valid_d;
    logic                 all_done_q;
    logic [31:0]          cnt_q;
    logic [N_THREADS-1:0] en_mask_q;

    logic                 excl;
    logic [TID_W-1:0]     excl_tid;
    logic [N_THREADS-1:0] elig;
    logic                 hold;
    logic                 found;
    logic [TID_W-1:0]     pick;
    logic [TID_W-1:0]     idx;

    // On the RUN->EXCL edge the live exc_thread already gates the grant.
    always_comb begin
        excl     = 1'b0;
        excl_tid = exc_tid_q;
        unique case (1'b1)
            (state_q == EXCL): begin
                excl     = 1'b1;
                excl_tid = exc_tid_q;
            end
            (state_q == RUN && bus.exc_en): begin
                excl     = 1'b1;
                excl_tid = bus.exc_thread;
            end
            default: ;
        endcase
    end

    always_comb begin
        elig = '0;
        for (int i = 0; i < N_THREADS; i++) begin
            elig[i] = en_mask_q[i] & ~bus.stalled[i] & ~bus.done[i]
                    & (~excl | (TID_W'(i) == excl_tid));
        end
    end

    always_comb begin
        found = 1'b0;
        pick  = rr_ptr_q;
        idx   = '0;
        for (int k = 1; k <= N_THREADS; k++) begin
            idx = TID_W'((int'(rr_ptr_q) + k) % N_THREADS);
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign hold = valid_q & elig[thr_q]
                & (qcnt_q < 4'(QUANTUM - 1));

    always_comb begin
        thr_d    = thr_q;
        rr_ptr_d = rr_ptr_q;
        qcnt_d   = '0;
        valid_d  = 1'b0;
        if (hold) begin
            valid_d = 1'b1;
            qcnt_d  = qcnt_q + 4'd1;
        end else if (found) begin
            valid_d  = 1'b1;
            thr_d    = pick;
            rr_ptr_d = pick;
        end
    end

    always_comb begin
        state_d   = state_q;
        exc_tid_d = exc_tid_q;
        unique case (state_q)
            RUN: begin
                if (bus.exc_en) begin
                    state_d   = EXCL;
                    exc_tid_d = bus.exc_thread;
                end
            end
            EXCL: begin
                if (!bus.exc_en) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            exc_tid_q  <= '0;
            rr_ptr_q   <= TID_W'(N_THREADS - 1);
            thr_q      <= '0;
            qcnt_q     <= '0;
            valid_q    <= 1'b0;
            all_done_q <= 1'b0;
            cnt_q      <= '0;
            en_mask_q  <= RESET_EN;
        end else begin
            state_q    <= state_d;
            exc_tid_q  <= exc_tid_d;
            rr_ptr_q   <= rr_ptr_d;
            thr_q      <= thr_d;
            qcnt_q     <= qcnt_d;
            valid_q    <= valid_d;
            all_done_q <= &(bus.done | ~en_mask_q);
            if (valid_d) cnt_q <= cnt_q + 32'd1;
            if (bus.cfg_wen) en_mask_q <= bus.cfg_mask;
        end
    end

    assign bus.scheduler_thread = thr_q;
    assign bus.issue_valid      = valid_q;
    assign bus.all_done         = all_done_q;
    assign bus.issue_cnt        = cnt_q;
endmodule

// File: tb/tb_thread_scheduler.sv
// Bench for thread_scheduler: vector table replayed through an
// expectation queue, plus a hand sequence for async reset in EXCL.
module tb_thread_scheduler;
    logic       clk;
    logic       rst;
    logic [7:0] stl, dn, cm;
    logic       ee, cw;
    logic [2:0] et;

    int n_chk  = 0;
    int n_pass = 0;

    thread_scheduler_if #(.N_THREADS(8), .TID_W(3)) ia();
    thread_scheduler_if #(.N_THREADS(8), .TID_W(3)) ib();

    assign ia.stalled    = stl;
    assign ia.done       = dn;
    assign ia.exc_en     = ee;
    assign ia.exc_thread = et;
    assign ia.cfg_wen    = cw;
    assign ia.cfg_mask   = cm;
    assign ib.stalled    = stl;
    assign ib.done       = dn;
    assign ib.exc_en     = ee;
    assign ib.exc_thread = et;
    assign ib.cfg_wen    = cw;
    assign ib.cfg_mask   = cm;

    thread_scheduler #(.N_THREADS(8), .TID_W(3), .QUANTUM(1)) dut_a (
        .clk(clk), .rst(rst), .bus(ia)
    );
    thread_scheduler #(.N_THREADS(8), .TID_W(3), .QUANTUM(3)) dut_b (
        .clk(clk), .rst(rst), .bus(ib)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sel;
        logic       rb;
        logic [7:0] stl, dn;
        logic       ee;
        logic [2:0] et;
        logic       cw;
        logic [7:0] cm;
        logic       ev;
        logic [2:0] eth;
        logic       ead;
        int         ecnt;
        int         id;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    function automatic void add(logic sel, logic rb, logic [7:0] s,
                                logic [7:0] d, logic e, logic [2:0] t,
                                logic w, logic [7:0] m, logic v,
                                logic [2:0] th, logic ad, int c);
        vec_t x;
        x.sel = sel; x.rb = rb; x.stl = s; x.dn = d; x.ee = e;
        x.et = t; x.cw = w; x.cm = m; x.ev = v; x.eth = th;
        x.ead = ad; x.ecnt = c; x.id = tbl.size();
        tbl.push_back(x);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    endtask

    task automatic idle_inputs();
        stl = '0; dn = '0; ee = 1'b0; et = '0; cw = 1'b0; cm = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_a_thr", 32'(ia.scheduler_thread), 32'd0);
        chk("rst_a_vld", 32'(ia.issue_valid), 32'd0);
        chk("rst_a_ad", 32'(ia.all_done), 32'd0);
        chk("rst_a_cnt", ia.issue_cnt, 32'd0);
        chk("rst_b_vld", 32'(ib.issue_valid), 32'd0);
        chk("rst_b_cnt", ib.issue_cnt, 32'd0);
        rst = 1'b1;
    endtask

    task automatic step(vec_t v);
        vec_t e;
        logic [2:0]  th;
        logic        vl, ad;
        logic [31:0] cn;
        stl = v.stl; dn = v.dn; ee = v.ee; et = v.et;
        cw = v.cw; cm = v.cm;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e  = sb.pop_front();
        th = e.sel ? ib.scheduler_thread : ia.scheduler_thread;
        vl = e.sel ? ib.issue_valid : ia.issue_valid;
        ad = e.sel ? ib.all_done : ia.all_done;
        cn = e.sel ? ib.issue_cnt : ia.issue_cnt;
        chk($sformatf("v%0d_valid", e.id), 32'(vl), 32'(e.ev));
        chk($sformatf("v%0d_thread", e.id), 32'(th), 32'(e.eth));
        chk($sformatf("v%0d_all_done", e.id), 32'(ad), 32'(e.ead));
        if (e.ecnt >= 0)
            chk($sformatf("v%0d_cnt", e.id), cn, 32'(e.ecnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        idle_inputs();

        // pure barrel, all eligible
        add(0,1,8'h00,8'h00,0,0,0,8'h00,1,3'd0,0,-1);
        for (int t = 1; t < 8; t++)
            add(0,0,8'h00,8'h00,0,0,0,8'h00,1,3'(t),0,-1);
        add(0,0,8'h00,8'h00,0,0,0,8'h00,1,3'd0,0,9);

        // stalled threads skipped, late unstall of thread 1
        add(0,1,8'h06,8'h00,0,0,0,8'h00,1,3'd0,0,-1);
        add(0,0,8'h06,8'h00,0,0,0,8'h00,1,3'd3,0,-1);
        add(0,0,8'h06,8'h00,0,0,0,8'h00,1,3'd4,0,-1);
        add(0,0,8'h06,8'h00,0,0,0,8'h00,1,3'd5,0,-1);
        add(0,0,8'h06,8'h00,0,0,0,8'h00,1,3'd6,0,-1);
        add(0,0,8'h06,8'h00,0,0,0,8'h00,1,3'd7,0,-1);
        add(0,0,8'h06,8'h00,0,0,0,8'h00,1,3'd0,0,-1);
        add(0,0,8'h04,8'h00,0,0,0,8'h00,1,3'd1,0,-1);
        add(0,0,8'h04,8'h00,0,0,0,8'h00,1,3'd3,0,-1);

        // exclusive mode on thread 5
        add(0,1,8'h00,8'h00,0,0,0,8'h00,1,3'd0,0,-1);
        add(0,0,8'h00,8'h00,0,0,0,8'h00,1,3'd1,0,-1);
        add(0,0,8'h00,8'h00,0,0,0,8'h00,1,3'd2,0,-1);
        add(0,0,8'h00,8'h00,1,5,0,8'h00,1,3'd5,0,-1);
        add(0,0,8'h00,8'h00,1,5,0,8'h00,1,3'd5,0,-1);
        add(0,0,8'h00,8'h00,1,3,0,8'h00,1,3'd5,0,-1);
        add(0,0,8'h20,8'h00,1,3,0,8'h00,0,3'd5,0,-1);
        add(0,0,8'h20,8'h00,0,0,0,8'h00,0,3'd5,0,-1);
        add(0,0,8'h20,8'h00,0,0,0,8'h00,1,3'd6,0,-1);
        add(0,0,8'h20,8'h00,0,0,0,8'h00,1,3'd7,0,-1);
        add(0,0,8'h20,8'h00,0,0,0,8'h00,1,3'd0,0,-1);

        // quantum 3 instance
        add(1,1,8'h00,8'h00,0,0,0,8'h00,1,3'd0,0,-1);
        add(1,0,8'h00,8'h00,0,0,0,8'h00,1,3'd0,0,-1);
        add(1,0,8'h00,8'h00,0,0,0,8'h00,1,3'd0,0,-1);
        add(1,0,8'h00,8'h00,0,0,0,8'h00,1,3'd1,0,-1);
        add(1,0,8'h00,8'h00,0,0,0,8'h00,1,3'd1,0,-1);
        add(1,0,8'h00,8'h00,0,0,0,8'h00,1,3'd1,0,-1);
        add(1,0,8'h00,8'h00,0,0,0,8'h00,1,3'd2,0,7);
        add(1,1,8'h00,8'h00,0,0,0,8'h00,1,3'd0,0,-1);
        add(1,0,8'h00,8'h00,0,0,0,8'h00,1,3'd0,0,-1);
        add(1,0,8'h00,8'h00,0,0,0,8'h00,1,3'd0,0,-1);
        add(1,0,8'h00,8'h00,0,0,0,8'h00,1,3'd1,0,-1);
        add(1,0,8'h02,8'h00,0,0,0,8'h00,1,3'd2,0,-1);
        add(1,0,8'h02,8'h00,0,0,0,8'h00,1,3'd2,0,-1);
        add(1,0,8'h02,8'h00,0,0,0,8'h00,1,3'd2,0,-1);
        add(1,0,8'h02,8'h00,0,0,0,8'h00,1,3'd3,0,-1);

        // enable mask, done, empty mask
        add(0,1,8'h00,8'h00,0,0,1,8'h81,1,3'd0,0,-1);
        add(0,0,8'h00,8'h00,0,0,0,8'h00,1,3'd7,0,-1);
        add(0,0,8'h00,8'h00,0,0,0,8'h00,1,3'd0,0,-1);
        add(0,0,8'h00,8'h00,0,0,0,8'h00,1,3'd7,0,-1);
        add(0,0,8'h00,8'h00,0,0,0,8'h00,1,3'd0,0,-1);
        add(0,0,8'h00,8'h81,0,0,0,8'h00,0,3'd0,1,-1);
        add(0,0,8'h00,8'h81,0,0,0,8'h00,0,3'd0,1,-1);
        add(0,0,8'h00,8'h00,0,0,1,8'h00,1,3'd7,0,-1);
        add(0,0,8'h00,8'h00,0,0,0,8'h00,0,3'd7,1,6);

        foreach (tbl[i]) begin
            if (tbl[i].rb) do_reset();
            step(tbl[i]);
        end

        // async reset in the middle of EXCL
        do_reset();
        begin
            vec_t v;
            v = '{sel:0, rb:0, stl:8'h00, dn:8'h00, ee:1'b0, et:3'd0,
                  cw:1'b0, cm:8'h00, ev:1'b1, eth:3'd0, ead:1'b0,
                  ecnt:-1, id:900};
            step(v);
            v.ee = 1'b1; v.et = 3'd4; v.eth = 3'd4; v.id = 901;
            step(v);
            v.id = 902;
            step(v);
            #2;
            rst = 1'b0;
            ee  = 1'b0;
            #1;
            chk("async_thr", 32'(ia.scheduler_thread), 32'd0);
            chk("async_vld", 32'(ia.issue_valid), 32'd0);
            chk("async_cnt", ia.issue_cnt, 32'd0);
            #2;
            rst = 1'b1;
            v.ee = 1'b0; v.et = 3'd0; v.eth = 3'd0; v.id = 903;
            step(v);
            v.eth = 3'd1; v.ecnt = 2; v.id = 904;
            step(v);
        end

        if (sb.size() != 0)
            chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
